// File: rtl/exec_controller.sv
// Execution sequencer for the single-cycle core: turns the step button and run switch
// into one-cycle cpu_en commit pulses, with PC breakpoint, EBREAK halt and retired count.
module exec_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 5000000,
  // Reset value of the retired-instruction counter.
  parameter logic [31:0] RETIRED_RST     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        step_btn_i,
  input  logic        run_i,
  input  logic        bp_enable_i,
  input  logic [31:0] bp_addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  output logic        cpu_en_o,
  output logic        halted_o,
  output logic [1:0]  state_o,
  output logic [31:0] retired_o
);

  // state | meaning
  // IDLE  | waiting for run or a step press, divider held at 0
  // STEP  | single issue cycle, back to IDLE next
  // RUN   | free-run, one issue slot every RUN_DIV cycles
  // BREAK | stopped on breakpoint or EBREAK until run drops
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_STEP  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DIV_LAST = 32'(RUN_DIV - 1);

  logic        btn_s1_q, btn_s2_q;
  logic        run_s1_q, run_s2_q;
  logic        db_q, db_d, db_prev_q, step_req_q;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] div_q, div_d;
  logic        skip_q, skip_d;
  logic [31:0] retired_q;
  logic        slot, stop, issue;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (btn_s2_q != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = btn_s2_q;
      else                     db_cnt_d = db_cnt_q + 32'd1;
    end
  end

  assign slot = (div_q == DIV_LAST);
  // Skip lets RUN resume from the breakpoint PC it stopped on; EBREAK is never skipped.
  assign stop = (instruction_i == EBREAK) ||
                (bp_enable_i && (pc_i == bp_addr_i) && !skip_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    skip_d  = skip_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (run_s2_q) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (step_req_q) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        issue   = 1'b1;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (!run_s2_q) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else if (slot) begin
          div_d  = '0;
          skip_d = 1'b0;
          if (stop) state_d = S_BREAK;
          else      issue   = 1'b1;
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      default: begin
        div_d = '0;
        if (!run_s2_q) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      step_req_q <= 1'b0;
      state_q    <= S_IDLE;
      div_q      <= '0;
      skip_q     <= 1'b0;
      retired_q  <= RETIRED_RST;
    end else begin
      btn_s1_q   <= step_btn_i;
      btn_s2_q   <= btn_s1_q;
      run_s1_q   <= run_i;
      run_s2_q   <= run_s1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      db_cnt_q   <= db_cnt_d;
      step_req_q <= db_q & ~db_prev_q;
      state_q    <= state_d;
      div_q      <= div_d;
      skip_q     <= skip_d;
      if (issue) retired_q <= retired_q + 32'd1;
    end
  end

  assign cpu_en_o  = issue & ~reset_i;
  assign halted_o  = (state_q == S_BREAK);
  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: two instances (RUN_DIV 3 and 1) checked every cycle against
// a behavioural model, plus directed scenarios with hand-computed expectations.
module tb_exec_controller;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int unsigned DEB    = 4;

  logic        clk = 1'b0;
  logic        rst, btn, run, bp_en;
  logic [31:0] bp_addr, instr, pc_a, pc_b;
  logic        en_a, en_b, halted_a, halted_b;
  logic [1:0]  state_a, state_b;
  logic [31:0] ret_a, ret_b;

  always #5 clk = ~clk;

  exec_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(3), .RETIRED_RST(32'hFFFF_FFFF)) dut_a (
    .clk_i(clk), .reset_i(rst), .step_btn_i(btn), .run_i(run), .bp_enable_i(bp_en),
    .bp_addr_i(bp_addr), .pc_i(pc_a), .instruction_i(instr),
    .cpu_en_o(en_a), .halted_o(halted_a), .state_o(state_a), .retired_o(ret_a));

  exec_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(1), .RETIRED_RST(32'h0000_0000)) dut_b (
    .clk_i(clk), .reset_i(rst), .step_btn_i(btn), .run_i(run), .bp_enable_i(bp_en),
    .bp_addr_i(bp_addr), .pc_i(pc_b), .instruction_i(instr),
    .cpu_en_o(en_b), .halted_o(halted_b), .state_o(state_b), .retired_o(ret_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 step, 2 run, 3 break; age = cycles spent in RUN so far.
  typedef struct {
    logic        bs1, bs2, rs1, rs2, db, dbp, sreq, skip;
    int unsigned dcnt, age;
    logic [1:0]  mode;
    logic [31:0] ret;
  } mdl_t;

  mdl_t        m [2];
  bit          mvalid [2];
  int unsigned rdiv [2];
  logic [31:0] rinit [2];

  task automatic mreset(input int k);
    m[k].bs1 = 0; m[k].bs2 = 0; m[k].rs1 = 0; m[k].rs2 = 0;
    m[k].db = 0; m[k].dbp = 0; m[k].sreq = 0; m[k].skip = 0;
    m[k].dcnt = 0; m[k].age = 0; m[k].mode = 2'd0; m[k].ret = rinit[k];
    mvalid[k] = 1'b1;
  endtask

  task automatic model_cycle(input int k, input logic [31:0] pcv, input logic a_en,
                             input logic a_halt, input logic [1:0] a_st, input logic [31:0] a_ret);
    mdl_t  c, n;
    bit    en;
    string nm;
    c  = m[k];
    n  = c;
    en = 1'b0;
    nm = (k == 0) ? "a" : "b";
    if (rst) begin
      if (mvalid[k]) begin
        chk({nm, ".cpu_en"}, {31'd0, a_en}, 32'd0);
        chk({nm, ".state"}, {30'd0, a_st}, {30'd0, c.mode});
        chk({nm, ".retired"}, a_ret, c.ret);
      end
      mreset(k);
      return;
    end
    n.bs1 = btn; n.bs2 = c.bs1; n.rs1 = run; n.rs2 = c.rs1;
    if (c.bs2 != c.db) begin
      if (c.dcnt + 1 >= DEB) begin n.db = c.bs2; n.dcnt = 0; end
      else n.dcnt = c.dcnt + 1;
    end else n.dcnt = 0;
    n.dbp  = c.db;
    n.sreq = c.db & ~c.dbp;
    case (c.mode)
      2'd0: if (c.rs2) begin n.mode = 2'd2; n.age = 0; n.skip = 1'b1; end
            else if (c.sreq) n.mode = 2'd1;
      2'd1: begin en = 1'b1; n.mode = 2'd0; end
      2'd2: if (!c.rs2) n.mode = 2'd0;
            else begin
              if ((c.age % rdiv[k]) == rdiv[k] - 1) begin
                if (instr == EBREAK || (bp_en && pcv == bp_addr && !c.skip)) n.mode = 2'd3;
                else en = 1'b1;
                n.skip = 1'b0;
              end
              n.age = c.age + 1;
            end
      default: if (!c.rs2) n.mode = 2'd0;
    endcase
    if (en) n.ret = c.ret + 32'd1;
    if (mvalid[k]) begin
      chk({nm, ".cpu_en"}, {31'd0, a_en}, {31'd0, en});
      chk({nm, ".state"}, {30'd0, a_st}, {30'd0, c.mode});
      chk({nm, ".halted"}, {31'd0, a_halt}, {31'd0, (c.mode == 2'd3)});
      chk({nm, ".retired"}, a_ret, c.ret);
    end
    m[k] = n;
  endtask

  logic        s_en_a, s_en_b;
  logic [31:0] pcs_b [$];

  task automatic cyc();
    @(negedge clk);
    s_en_a = en_a;
    s_en_b = en_b;
    if (en_b) pcs_b.push_back(pc_b);
    model_cycle(0, pc_a, en_a, halted_a, state_a, ret_a);
    model_cycle(1, pc_b, en_b, halted_b, state_b, ret_b);
    @(posedge clk);
    #1;
    if (s_en_a) pc_a = pc_a + 32'd4;
    if (s_en_b) pc_b = pc_b + 32'd4;
  endtask

  initial begin
    int first, npa, npb, last, nstep, hold_left;
    logic [31:0] r0;
    rdiv[0] = 3; rdiv[1] = 1;
    rinit[0] = 32'hFFFF_FFFF; rinit[1] = 32'h0;
    mvalid[0] = 1'b0; mvalid[1] = 1'b0;
    rst = 1; btn = 0; run = 0; bp_en = 0; bp_addr = 32'h10; instr = NOP;
    pc_a = 0; pc_b = 0;
    #1;
    repeat (3) cyc();
    rst = 0;
    cyc();
    chk("reset_state_b", {30'd0, state_b}, 32'd0);
    chk("reset_retired_b", ret_b, 32'd0);
    chk("reset_halted_b", {31'd0, halted_b}, 32'd0);

    // 3-cycle bounce, then a clean hold: one pulse, 7 cycles after the hold is first sampled
    btn = 1; repeat (3) cyc();
    btn = 0; repeat (3) cyc();
    btn = 1; first = -1; npb = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_en_b) begin npb++; if (first < 0) first = i; end
    end
    btn = 0;
    for (int i = 0; i < 15; i++) begin cyc(); if (s_en_b) npb++; end
    chk("step_latency", 32'(first), 32'd8);
    chk("step_pulse_count", 32'(npb), 32'd1);
    chk("step_retired_b", ret_b, 32'd1);
    chk("wrap_retired_a_0", ret_a, 32'h0000_0000);

    btn = 1; repeat (12) cyc();
    btn = 0; repeat (12) cyc();
    chk("wrap_retired_a_1", ret_a, 32'h0000_0001);
    chk("step2_retired_b", ret_b, 32'd2);

    // free run, RUN_DIV=3
    r0 = ret_a; npa = 0; last = -1;
    run = 1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (s_en_a) begin
        if (last >= 0) chk("run_period_a", 32'(i - last), 32'd3);
        else chk("run_first_slot_a", 32'(i), 32'd5);
        last = i; npa++;
      end
    end
    chk("run_pulses_a", 32'(npa), 32'd9);
    chk("run_retired_a", ret_a - r0, 32'd9);
    run = 0; npa = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (i >= 2 && s_en_a) npa++; end
    chk("run_stop_pulses_a", 32'(npa), 32'd0);
    chk("run_stop_state_a", {30'd0, state_a}, 32'd0);

    // breakpoint at 0x10 with RUN_DIV=1, then resume from it
    bp_en = 1; bp_addr = 32'h10; pc_a = 0; pc_b = 0; pcs_b.delete();
    run = 1;
    repeat (12) cyc();
    chk("bp_pulse_count", 32'(pcs_b.size()), 32'd4);
    for (int i = 0; i < 4 && i < pcs_b.size(); i++) chk("bp_pulse_pc", pcs_b[i], 32'(4 * i));
    chk("bp_halted_b", {31'd0, halted_b}, 32'd1);
    chk("bp_state_b", {30'd0, state_b}, 32'd3);
    run = 0; repeat (6) cyc();
    chk("bp_release_state_b", {30'd0, state_b}, 32'd0);
    pcs_b.delete();
    run = 1; repeat (6) cyc();
    chk("resume_count", 32'(pcs_b.size()), 32'd3);
    if (pcs_b.size() > 0) chk("resume_first_pc", pcs_b[0], 32'h10);
    run = 0; bp_en = 0; repeat (6) cyc();

    // EBREAK blocks the issue slot; stepping still works afterwards
    instr = EBREAK; npa = 0; npb = 0;
    run = 1;
    for (int i = 0; i < 12; i++) begin cyc(); npa += s_en_a; npb += s_en_b; end
    chk("ebreak_pulses_a", 32'(npa), 32'd0);
    chk("ebreak_pulses_b", 32'(npb), 32'd0);
    chk("ebreak_state_a", {30'd0, state_a}, 32'd3);
    chk("ebreak_state_b", {30'd0, state_b}, 32'd3);
    run = 0; repeat (6) cyc();
    npb = 0;
    btn = 1; for (int i = 0; i < 12; i++) begin cyc(); npb += s_en_b; end
    btn = 0; for (int i = 0; i < 10; i++) begin cyc(); npb += s_en_b; end
    chk("ebreak_step_pulses_b", 32'(npb), 32'd1);
    instr = NOP;

    // run rises in the same cycle step_req is presented: RUN wins, no STEP
    btn = 1; repeat (5) cyc();
    run = 1; nstep = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (state_a == 2'b01) nstep++;
      if (state_b == 2'b01) nstep++;
    end
    chk("simul_no_step", 32'(nstep), 32'd0);
    chk("simul_state_b", {30'd0, state_b}, 32'd2);
    btn = 0;

    // reset during RUN with RUN_DIV=1
    repeat (2) cyc();
    chk("pre_reset_en_b", {31'd0, s_en_b}, 32'd1);
    rst = 1;
    cyc(); chk("reset_cyc1_en_b", {31'd0, s_en_b}, 32'd0);
    cyc(); chk("reset_cyc2_en_b", {31'd0, s_en_b}, 32'd0);
    rst = 0;
    cyc();
    chk("post_reset_state_b", {30'd0, state_b}, 32'd0);
    chk("post_reset_retired_b", ret_b, 32'd0);
    chk("post_reset_halted_b", {31'd0, halted_b}, 32'd0);
    chk("post_reset_retired_a", ret_a, 32'hFFFF_FFFF);

    // randomized traffic
    run = 0; hold_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_left == 0) begin
        btn = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      if ($urandom_range(0, 29) == 0) run = ~run;
      if ($urandom_range(0, 19) == 0) bp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bp_addr = 32'($urandom_range(0, 7)) * 32'd4;
      instr = ($urandom_range(0, 15) == 0) ? EBREAK : NOP;
      if ($urandom_range(0, 7) == 0) pc_a = 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 7) == 0) pc_b = 32'($urandom_range(0, 7)) * 32'd4;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
# exec_controller

Execution sequencer for the single-cycle RISC-V core on the DE1-SoC. It turns the raw step button and run switch into single-cycle `cpu_en` enable pulses that gate every state update in the core: PC, register file and data-memory writes. It supports single-step, free-run at a divided rate, a PC breakpoint and halt-on-EBREAK. It also keeps a retired-instruction counter for the displays.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized button level must differ from the debounced level before the change is accepted (10 ms at 50 MHz); must be ≥1.
- `RUN_DIV`, default 5000000: RUN-mode issue period in cycles (10 Hz at 50 MHz); must be ≥1.
- `clk`  in  1  system clock; the single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `step_btn`  in  1  raw asynchronous button level, 1 = pressed (already inverted from KEY).
- `run`  in  1  level, 1 = request RUN mode.
- `bp_enable`  in  1  enables the PC breakpoint.
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  current core PC.
- `instruction`  in  32  instruction at `pc`.
- `cpu_en`  out  1  core commits state on the rising edge that ends a cycle in which `cpu_en`=1.
- `halted`  out  1  1 while in BREAK.
- `state`  out  2  00 IDLE, 01 STEP, 10 RUN, 11 BREAK.
- `retired`  out  32  count of issued `cpu_en` pulses.

## Operation
- Input conditioning:
  - `step_btn` passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer counter increments while synced ≠ debounced and clears when equal.
  - When the count reaches `DEBOUNCE_CYCLES`-1 while still differing, debounced takes the synced value at the next edge.
  - `step_req` is a one-cycle registered pulse on the rising edge of debounced; releasing the button produces nothing.
  - `run` is 2-flop synchronized; no debounce.
- IDLE: `cpu_en`=0, divider held at 0.
  - synced run=1 → RUN. Run has priority over `step_req`, and a simultaneous `step_req` is dropped.
  - Otherwise `step_req` → STEP.
- STEP: `cpu_en`=1 for exactly this one cycle, then → IDLE.
  - Breakpoint and EBREAK checks are not applied, so stepping always advances.
  - A `step_req` arriving while in STEP is dropped.
- RUN:
  - Divider counts 0..`RUN_DIV`-1 and wraps. A cycle with divider = `RUN_DIV`-1 is an issue slot.
  - Stop condition: `instruction`==32'h00100073 (EBREAK), or `bp_enable` && `pc`==`bp_addr`.
  - Stop condition in an issue slot: `cpu_en`=0 that cycle; → BREAK.
  - No stop condition in an issue slot: `cpu_en`=1.
  - Skip flag: set on entry to RUN, cleared after the first issue slot. While set, the breakpoint compare (not EBREAK) is ignored, so RUN can resume from a breakpoint PC.
  - synced run=0 → IDLE. No pulse is issued in that cycle and the divider clears.
  - `step_req` is ignored.
- BREAK: `halted`=1, `cpu_en`=0.
  - synced run=0 → IDLE.
  - `step_req` is ignored until back in IDLE.
- `retired` increments by 1 on every edge ending a cycle with `cpu_en`=1; it wraps from 32'hFFFFFFFF to 0.
- Stop conditions are evaluated combinationally against the current `pc`/`instruction` in the issue cycle itself. This makes them valid for `RUN_DIV`=1, where `pc` changes every cycle.

## Timing
- Reset values: `state`=IDLE, `cpu_en`=0, `halted`=0, `retired`=0. Divider, debouncer counter, synchronizers, debounced level, `step_req` and skip flag are all 0.
- Reset asserted mid-STEP or mid-RUN: `cpu_en`=0 in the reset cycle itself (reset gates `cpu_en` combinationally); all state returns to reset values at that edge.
- `cpu_en` is a decode of registered state, the divider and the combinational stop check; it has no glitch-free requirement beyond single-clock use.
- Step latency: `step_btn` held high from edge E0 gives `cpu_en`=1 in the cycle starting at edge E0+`DEBOUNCE_CYCLES`+3.
- Button bounces shorter than `DEBOUNCE_CYCLES` cycles produce no pulse.
- RUN:
  - First issue slot is the `RUN_DIV`-th cycle after the edge that enters RUN.
  - After that, one slot every `RUN_DIV` cycles.
  - With `RUN_DIV`=1, every RUN cycle is a slot.
- BREAK entry: `halted` rises at the edge ending the blocked issue slot.
- `retired` updates at the same edge the core commits.

## Test plan
- **Reset:** assert `reset` for 2 cycles while in RUN with `RUN_DIV`=1 → `cpu_en`=0 in both reset cycles; after reset `state`=00, `retired`=0, `halted`=0.
- **Step debounce:** `DEBOUNCE_CYCLES`=4; pulse `step_btn` high for 3 cycles, then hold high for 20 → exactly one `cpu_en` pulse, 7 cycles after the hold begins; `retired`=1; releasing gives no pulse.
- **Free run:** `RUN_DIV`=3, `run`=1 for 30 cycles, no stop conditions → `cpu_en` period exactly 3 cycles; `retired` equals the pulse count; `run`=0 → IDLE, no further pulses.
- **Breakpoint and resume:**
  - `RUN_DIV`=1, `bp_enable`=1, `bp_addr`=32'h10; model PC +4 per pulse from 0 → pulses at PC 0, 4, 8 and 0xC; no pulse at 0x10; `halted`=1, `state`=11.
  - `run`=0 then `run`=1 → resumes with a pulse at PC 0x10.
- **EBREAK:** RUN with `instruction`=32'h00100073 at the issue slot → `cpu_en` stays 0, → BREAK; in IDLE, a step press still issues one pulse.
- **Counter wrap and simultaneous events:**
  - Preload `retired` near 32'hFFFFFFFF and issue two steps → wraps to 32'h00000000, then 32'h00000001.
  - `run` rising in the same cycle as `step_req` → RUN entered; no STEP pulse.
